// File: rtl/proc_pkg.sv
// Shared types and width constants for the instruction/data memory arbiter.
// The optional round-robin tie-break is enabled with the MEM_ARB_RR_EN macro.
package proc_pkg;

  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 64;
  localparam int INSTR_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the fetch port, the data port and the
// shared single-port memory. The arbiter uses the slave view; the bench uses the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W  = proc_pkg::ADDR_W,
  parameter int DATA_W  = proc_pkg::DATA_W,
  parameter int INSTR_W = proc_pkg::INSTR_W
);

  // Handshake: a requester holds req (with its address/data stable) until it
  // sees gnt high in the same cycle; gnt is combinational from req in IDLE.
  // The matching valid pulses for exactly one cycle, the cycle after gnt.
  logic               if_req;
  logic [31:0]        if_addr;
  logic               if_gnt;
  logic               if_valid;
  logic [INSTR_W-1:0] if_rdata;

  logic               dm_req;
  logic               dm_we;
  logic [ADDR_W-1:0]  dm_addr;
  logic [DATA_W-1:0]  dm_wdata;
  logic               dm_gnt;
  logic               dm_valid;
  logic [DATA_W-1:0]  dm_rdata;

  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_we;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
           mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and data requesters.
// Fixed priority (data wins ties) unless MEM_ARB_RR_EN selects round-robin ties.
module mem_arb_pick
  import proc_pkg::*;
(
  input  logic   if_req,
  input  logic   dm_req,
  input  owner_t last_owner,
  output owner_t winner
);

  always_comb begin
    winner = OWN_IF;
    if (if_req && dm_req) begin
`ifdef MEM_ARB_RR_EN
      // On a tie, whoever did not win last time goes now.
      winner = (last_owner == OWN_DM) ? OWN_IF : OWN_DM;
`else
      winner = OWN_DM;
`endif
    end else if (dm_req) begin
      winner = OWN_DM;
    end
  end

`ifndef MEM_ARB_RR_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-state arbiter sharing one synchronous single-port memory between
// instruction fetch and data accesses. MEM_ARB_RR_EN enables round-robin ties.
module mem_arbiter #(
  parameter int ADDR_W  = proc_pkg::ADDR_W,
  parameter int DATA_W  = proc_pkg::DATA_W,
  parameter int INSTR_W = proc_pkg::INSTR_W
) (
  input  logic             clk,
  input  logic             reset,
  mem_arbiter_if.slave     bus,
  output proc_pkg::state_t state_dbg
);

  import proc_pkg::*;

  state_t             state_q, state_d;
  owner_t             owner_q, winner, last_owner;
  logic               grant;
  logic               resp_if, resp_dm;
  logic               if_sel_q, dm_load_q;
  logic [INSTR_W-1:0] if_fetch, if_rdata_q;
  logic [DATA_W-1:0]  dm_rdata_q;

  // owner_q routes the response and doubles as the last-grant record for
  // the round-robin tie-break; fixed priority never looks at it.
`ifdef MEM_ARB_RR_EN
  assign last_owner = owner_q;
`else
  assign last_owner = OWN_IF;
`endif

  mem_arb_pick u_pick (
    .if_req     (bus.if_req),
    .dm_req     (bus.dm_req),
    .last_owner (last_owner),
    .winner     (winner)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Reset also gates the combinational grant so nothing is granted while held.
  always_comb begin
    state_d       = state_q;
    grant         = 1'b0;
    bus.if_gnt    = 1'b0;
    bus.dm_gnt    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    case (state_q)
      IDLE: begin
        if (reset && (bus.if_req || bus.dm_req)) begin
          grant   = 1'b1;
          state_d = RESP;
          if (winner == OWN_DM) begin
            bus.dm_gnt    = 1'b1;
            bus.mem_addr  = bus.dm_addr;
            bus.mem_we    = bus.dm_we;
            bus.mem_wdata = bus.dm_wdata;
          end else begin
            bus.if_gnt    = 1'b1;
            bus.mem_addr  = bus.if_addr[ADDR_W+2:3];
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign resp_if      = (state_q == RESP) && (owner_q == OWN_IF);
  assign resp_dm      = (state_q == RESP) && (owner_q == OWN_DM);
  assign bus.if_valid = resp_if;
  assign bus.dm_valid = resp_dm;
  assign if_fetch     = if_sel_q ? bus.mem_rdata[INSTR_W +: INSTR_W]
                                 : bus.mem_rdata[INSTR_W-1:0];

  // The response cycle forwards the memory word directly so data lines up
  // with valid; the registers then hold it until the next same-kind response.
  assign bus.if_rdata = resp_if ? if_fetch : if_rdata_q;
  assign bus.dm_rdata = (resp_dm && dm_load_q) ? bus.mem_rdata : dm_rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q    <= OWN_IF;
      if_sel_q   <= 1'b0;
      dm_load_q  <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (grant) begin
        owner_q   <= winner;
        if_sel_q  <= bus.if_addr[2];
        dm_load_q <= !bus.dm_we;
      end
      if (resp_if)              if_rdata_q <= if_fetch;
      if (resp_dm && dm_load_q) dm_rdata_q <= bus.mem_rdata;
    end
  end

  assign state_dbg = state_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+3], bus.if_addr[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed corner sequences and random
// traffic checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
  import proc_pkg::*;

  localparam int NV = 7;

  typedef struct {
    bit                if_req;
    logic [31:0]       if_addr;
    bit                dm_req;
    bit                dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    bit                e_if_gnt;
    bit                e_dm_gnt;
    logic [ADDR_W-1:0] e_mem_addr;
    bit                e_mem_we;
    logic [DATA_W-1:0] e_mem_wdata;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic   clk = 1'b0;
  logic   reset;
  state_t dbg;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (dbg)
  );

  // ---------------- environment memory ----------------
  logic [DATA_W-1:0] mem     [2**ADDR_W];
  logic [DATA_W-1:0] ref_mem [2**ADDR_W];

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  // ---------------- scoreboard / model state ----------------
  int                 n_checks = 0;
  int                 n_errors = 0;
  logic [DATA_W-1:0]  exp_q[$];
  bit                 m_busy;
  bit                 m_owner_dm;
  bit                 m_resp_load;
  bit                 m_last_dm;
  logic [INSTR_W-1:0] m_exp_if;
  logic [DATA_W-1:0]  m_exp_dm;
  bit                 seen_if_gnt, seen_dm_gnt;
  vec_t               vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs just after the rising edge, check on the falling edge.
  task automatic step(input bit rst, input bit ifr, input logic [31:0] ifa,
                      input bit dmr, input bit dmwe, input logic [ADDR_W-1:0] dma,
                      input logic [DATA_W-1:0] dmwd);
    bit                e_ifg, e_dmg;
    state_t            e_state;
    logic [DATA_W-1:0] word;
    @(posedge clk);
    #1;
    reset        = rst;
    bus.if_req   = ifr;
    bus.if_addr  = ifa;
    bus.dm_req   = dmr;
    bus.dm_we    = dmwe;
    bus.dm_addr  = dma;
    bus.dm_wdata = dmwd;
    @(negedge clk);
    seen_if_gnt = bus.if_gnt;
    seen_dm_gnt = bus.dm_gnt;
    if (!rst) begin
      chk("rst_if_gnt",   bus.if_gnt,   0);
      chk("rst_dm_gnt",   bus.dm_gnt,   0);
      chk("rst_if_valid", bus.if_valid, 0);
      chk("rst_dm_valid", bus.dm_valid, 0);
      chk("rst_if_rdata", bus.if_rdata, 0);
      chk("rst_dm_rdata", bus.dm_rdata, 0);
      chk("rst_mem_we",   bus.mem_we,   0);
      chk("rst_state",    dbg,          IDLE);
      m_busy    = 0;
      m_last_dm = 0;
      m_exp_if  = '0;
      m_exp_dm  = '0;
      exp_q.delete();
      return;
    end
    e_state = m_busy ? RESP : IDLE;
    chk("state",    dbg,          e_state);
    chk("if_valid", bus.if_valid, m_busy && !m_owner_dm);
    chk("dm_valid", bus.dm_valid, m_busy && m_owner_dm);
    if (m_busy && !m_owner_dm) begin
      word     = exp_q.pop_front();
      m_exp_if = word[INSTR_W-1:0];
    end else if (m_busy && m_resp_load) begin
      m_exp_dm = exp_q.pop_front();
    end
    chk("if_rdata", bus.if_rdata, m_exp_if);
    chk("dm_rdata", bus.dm_rdata, m_exp_dm);
    // Only a cycle that follows a non-grant cycle may grant.
    e_ifg = 0;
    e_dmg = 0;
    if (!m_busy) begin
      if (ifr && dmr) begin
`ifdef MEM_ARB_RR_EN
        if (m_last_dm) e_ifg = 1; else e_dmg = 1;
`else
        e_dmg = 1;
`endif
      end else if (ifr) e_ifg = 1;
      else if (dmr)     e_dmg = 1;
    end
    chk("if_gnt", bus.if_gnt, e_ifg);
    chk("dm_gnt", bus.dm_gnt, e_dmg);
    if (e_dmg) begin
      chk("dm_mem_addr",  bus.mem_addr,  dma);
      chk("dm_mem_we",    bus.mem_we,    dmwe);
      chk("dm_mem_wdata", bus.mem_wdata, dmwd);
      if (dmwe) begin
        ref_mem[dma] = dmwd;
        m_resp_load  = 0;
      end else begin
        exp_q.push_back(ref_mem[dma]);
        m_resp_load = 1;
      end
      m_busy = 1; m_owner_dm = 1; m_last_dm = 1;
    end else if (e_ifg) begin
      chk("if_mem_addr",  bus.mem_addr,  ifa[ADDR_W+2:3]);
      chk("if_mem_we",    bus.mem_we,    0);
      chk("if_mem_wdata", bus.mem_wdata, 0);
      word = ref_mem[ifa[ADDR_W+2:3]];
      exp_q.push_back(ifa[2] ? {32'h0, word[63:32]} : {32'h0, word[31:0]});
      m_busy = 1; m_owner_dm = 0; m_last_dm = 0;
    end else begin
      chk("idle_mem_we",    bus.mem_we,    0);
      chk("idle_mem_wdata", bus.mem_wdata, 0);
      m_busy = 0;
    end
  endtask

  task automatic idle(input bit rst);
    step(rst, 0, '0, 0, 0, '0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit                ifp, dmp, dm_we_r;
    logic [31:0]       if_a;
    logic [ADDR_W-1:0] dm_a;
    logic [DATA_W-1:0] dm_d;
    int                n_ifg, n_dmg, n_val;
    logic [3:0]        ord;

    reset = 1'b0;
    bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_we = 0;
    bus.dm_addr = '0; bus.dm_wdata = '0;
    for (int i = 0; i < 2**ADDR_W; i++) begin
      mem[i]     = {32'h1000_0000 + i, 32'h2000_0000 + i};
      ref_mem[i] = mem[i];
    end
    mem[0] = 64'hDEAD_BEEF_CAFE_F00D; ref_mem[0] = mem[0];
    mem[1] = 64'hAAAA_BBBB_1111_2222; ref_mem[1] = mem[1];

    idle(0);
    idle(0);

    // Vector table: single-cycle grant decisions from IDLE.
    vecs[0] = '{0, 32'h0,    0, 0, 5'd0,  64'h0,                  0, 0, 5'd0,  0, 64'h0};
    vecs[1] = '{1, 32'h0C,   0, 0, 5'd0,  64'h0,                  1, 0, 5'd1,  0, 64'h0};
    vecs[2] = '{1, 32'h104,  0, 0, 5'd0,  64'h0,                  1, 0, 5'd0,  0, 64'h0};
    vecs[3] = '{1, 32'hFB,   0, 0, 5'd0,  64'h0,                  1, 0, 5'd31, 0, 64'h0};
    vecs[4] = '{0, 32'h0,    1, 1, 5'd3,  64'h0123_4567_89AB_CDEF, 0, 1, 5'd3,  1, 64'h0123_4567_89AB_CDEF};
    vecs[5] = '{0, 32'h0,    1, 0, 5'd3,  64'h55,                 0, 1, 5'd3,  0, 64'h55};
    vecs[6] = '{0, 32'h0,    1, 1, 5'd31, 64'hFEED_0000_0000_BEEF, 0, 1, 5'd31, 1, 64'hFEED_0000_0000_BEEF};
    idle(1);
    for (int i = 0; i < NV; i++) begin
      step(1, vecs[i].if_req, vecs[i].if_addr, vecs[i].dm_req, vecs[i].dm_we,
           vecs[i].dm_addr, vecs[i].dm_wdata);
      chk("tbl_if_gnt",    bus.if_gnt,    vecs[i].e_if_gnt);
      chk("tbl_dm_gnt",    bus.dm_gnt,    vecs[i].e_dm_gnt);
      chk("tbl_mem_we",    bus.mem_we,    vecs[i].e_mem_we);
      chk("tbl_mem_wdata", bus.mem_wdata, vecs[i].e_mem_wdata);
      if (vecs[i].e_if_gnt || vecs[i].e_dm_gnt)
        chk("tbl_mem_addr", bus.mem_addr, vecs[i].e_mem_addr);
      idle(1);
    end

    // Fetch alone: word 1 upper half.
    step(1, 1, 32'h0C, 0, 0, '0, '0);
    chk("f_gnt", bus.if_gnt, 1);
    idle(1);
    chk("f_valid", bus.if_valid, 1);
    chk("f_data",  bus.if_rdata, 32'hAAAA_BBBB);

    // Store then load of the same word.
    step(1, 0, '0, 1, 1, 5'd3, 64'h0123_4567_89AB_CDEF);
    idle(1);
    chk("st_ack", bus.dm_valid, 1);
    step(1, 0, '0, 1, 0, 5'd3, '0);
    idle(1);
    chk("ld_valid", bus.dm_valid, 1);
    chk("ld_data",  bus.dm_rdata, 64'h0123_4567_89AB_CDEF);

    // Address wrap selects word 0, upper half.
    step(1, 1, 32'h104, 0, 0, '0, '0);
    chk("wrap_addr", bus.mem_addr, 0);
    idle(1);
    chk("wrap_data", bus.if_rdata, 32'hDEAD_BEEF);

    // Both requesters held for eight cycles.
    idle(0);
    idle(1);
    n_ifg = 0; n_dmg = 0; n_val = 0; ord = '0;
    for (int c = 0; c < 8; c++) begin
      step(1, 1, 32'h0C, 1, 0, 5'd3, '0);
      if (bus.if_gnt) begin n_ifg++; ord = {ord[2:0], 1'b0}; end
      if (bus.dm_gnt) begin n_dmg++; ord = {ord[2:0], 1'b1}; end
      n_val += int'(bus.if_valid) + int'(bus.dm_valid);
    end
`ifdef MEM_ARB_RR_EN
    chk("tie_order", ord, 4'b1010);
`else
    chk("tie_if_gnts", n_ifg, 0);
    chk("tie_dm_gnts", n_dmg, 4);
`endif
    chk("tie_valids", n_val, 4);
    idle(1);

    // Reset during the response of a store; pending fetch granted after release.
    step(1, 0, '0, 1, 1, 5'd7, 64'h7777_0000_1234_5678);
    step(0, 1, 32'h0C, 0, 0, '0, '0);
    chk("rr_dm_valid", bus.dm_valid, 0);
    chk("rr_state",    dbg,          IDLE);
    step(1, 1, 32'h0C, 0, 0, '0, '0);
    chk("rr_first_gnt", bus.if_gnt, 1);
    idle(1);
    step(1, 0, '0, 1, 0, 5'd7, '0);
    idle(1);
    chk("rr_store_kept", bus.dm_rdata, 64'h7777_0000_1234_5678);

    // Random traffic with cancellations and occasional resets.
    ifp = 0; dmp = 0; if_a = '0; dm_a = '0; dm_d = '0; dm_we_r = 0;
    seen_if_gnt = 0; seen_dm_gnt = 0;
    for (int c = 0; c < 800; c++) begin
      bit rst_v;
      if (seen_if_gnt) ifp = 0;
      if (seen_dm_gnt) dmp = 0;
      if (ifp && $urandom_range(0, 7) == 0) ifp = 0;
      if (dmp && $urandom_range(0, 7) == 0) dmp = 0;
      if (!ifp && $urandom_range(0, 1) == 1) begin
        ifp  = 1;
        if_a = $urandom;
      end
      if (!dmp && $urandom_range(0, 1) == 1) begin
        dmp     = 1;
        dm_we_r = 1'($urandom_range(0, 1));
        dm_a    = ADDR_W'($urandom_range(0, 2**ADDR_W - 1));
        dm_d    = {$urandom, $urandom};
      end
      rst_v = ($urandom_range(0, 99) != 0);
      step(rst_v, ifp, if_a, dmp, dm_we_r, dm_a, dm_d);
    end
    idle(1);
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, shared-memory word address width.
REQ-002 Parameter DATA_W, default 64, shared-memory word width.
REQ-003 Parameter INSTR_W, default 32, instruction width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 if_req / if_addr  input  1 / 32  fetch request; byte address taken from PC.
REQ-007 if_gnt / if_valid  output  1 / 1  fetch granted / fetch data valid.
REQ-008 if_rdata  output  INSTR_W  fetched instruction.
REQ-009 dm_req / dm_we  input  1 / 1  data request; 1 = store.
REQ-010 dm_addr / dm_wdata  input  ADDR_W / DATA_W  data word address / store data.
REQ-011 dm_gnt / dm_valid  output  1 / 1  data granted / load data valid or store acknowledged.
REQ-012 dm_rdata  output  DATA_W  load data.
REQ-013 mem_addr / mem_we / mem_wdata  output  ADDR_W / 1 / DATA_W  shared single-port memory port.
REQ-014 mem_rdata  input  DATA_W  memory read data, synchronous read, 1-cycle latency.

Function
REQ-015 FSM states: IDLE and RESP only.
REQ-016 IDLE with any request: grant one requester combinationally; drive mem_* from the winner in the same cycle; go to RESP.
REQ-017 IDLE with no request: all gnt low, mem_we low, stay in IDLE.
REQ-018 RESP: assert the owner's valid for exactly one cycle, both gnt low, mem_we low, return to IDLE; one access every 2 cycles at most.
REQ-019 Arbitration without the macro: fixed priority; dm beats if on a tie.
REQ-020 Fetch: mem_addr = if_addr[ADDR_W+2:3], mem_we = 0; address bits above ADDR_W+2 are ignored, so the address wraps; if_addr[1:0] is ignored.
REQ-021 Fetch data: if_rdata = mem_rdata[31:0] when the registered if_addr[2] is 0, mem_rdata[63:32] when it is 1.
REQ-022 Data access: mem_addr = dm_addr; mem_we = dm_we; mem_wdata = dm_wdata.
REQ-023 On a load, dm_rdata captures mem_rdata in RESP; on a store, dm_rdata is unchanged.
REQ-024 if_rdata and dm_rdata are registered and hold until the next response of their own kind.
REQ-025 Requests are sampled only in IDLE; a request held during RESP is granted in the following IDLE cycle.
REQ-026 A requester keeps req asserted until it sees gnt; dropping req before gnt cancels it with no side effect.
REQ-027 mem_wdata = 0 whenever the data port is not the winner.

Reset
REQ-028 Asserting reset (low) immediately forces: state IDLE, all gnt/valid 0, if_rdata 0, dm_rdata 0, last-owner register = IF.
REQ-029 Reset during RESP suppresses valid; a store already sampled by the memory is not rolled back.
REQ-030 The first IDLE cycle after reset release may grant.

Configuration
REQ-031 Macro MEM_ARB_RR_EN: when defined, ties go round-robin; the winner is the requester that did not own the last grant; the last-owner register updates on every grant.
REQ-032 When MEM_ARB_RR_EN is undefined, fixed priority per REQ-019 applies and the last-owner register is not implemented.

Structure
REQ-033 Package proc_pkg holds the state enum {IDLE, RESP}, the owner enum {OWN_IF, OWN_DM}, and width constants ADDR_W/DATA_W/INSTR_W.
REQ-034 Winner selection is a sub-module, mem_arb_pick: combinational, with inputs if_req, dm_req and last_owner, and output winner.

Verification
REQ-035 Fetch alone: if_req=1, if_addr=0x0C, mem word 1 = 0xAAAA_BBBB_1111_2222 -> if_gnt in cycle 0; if_valid in cycle 1; if_rdata=0xAAAA_BBBB.
REQ-036 Store then load: dm store addr 3, data 0x0123_4567_89AB_CDEF; then load addr 3 -> first dm_valid as store ack; second dm_valid with dm_rdata=0x0123_4567_89AB_CDEF.
REQ-037 Tie, fixed priority: if_req=dm_req=1 held -> grant order dm, dm, dm... and if never granted while dm_req stays high.
REQ-038 Tie with MEM_ARB_RR_EN: both held for 8 cycles -> grant order dm, if, dm, if; 4 valids total.
REQ-039 Wrap: if_addr=0x104 -> mem_addr=0, upper half selected.
REQ-040 Reset mid-RESP: reset low in RESP -> no valid, state IDLE; after release, a pending if_req is granted on the first cycle.
